// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU bus bridge: FSM state encoding and
// the wait-state clamp applied when an access is launched.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  function automatic logic [31:0] clamp_wait(input logic [31:0] cfg, input logic [31:0] max_w);
    return (cfg > max_w) ? max_w : cfg;
  endfunction

endpackage

// File: rtl/bus_trace_ring.sv
// Ring buffer of completed bus accesses {address, write flag}; index 0 reads
// the newest entry, with one clock of read latency.
module bus_trace_ring #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [AW-1:0]              ab_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
  output logic [AW-1:0]              rd_ab_o,
  output logic                       rd_we_o,
  output logic [$clog2(DEPTH):0]     cnt_o
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] ab;
    logic          we;
  } trace_entry_t;

  trace_entry_t   mem_q [DEPTH];
  trace_entry_t   rd_q;
  logic [IW-1:0]  wr_ptr_q;
  logic [IW-1:0]  rd_addr;
  logic [IW:0]    cnt_q;

  // Newest entry sits one slot behind the write pointer; indices wrap.
  assign rd_addr = wr_ptr_q - IW'(1) - rd_idx_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
    end else begin
      rd_q <= mem_q[rd_addr];
      if (wr_en_i) begin
        wr_ptr_q <= wr_ptr_q + IW'(1);
        if (cnt_q != (IW+1)'(DEPTH)) cnt_q <= cnt_q + (IW+1)'(1);
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; cnt_o says how many entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= '{ab: ab_i, we: we_i};
  end

  assign rd_ab_o = rd_q.ab;
  assign rd_we_o = rd_q.we;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/cpu_bus_bridge.sv
// Registered bridge from a CPU core's combinational bus to memory/IO with a
// clock-enable divider, wait states, req/ack handshake, RDY stall and IRQ/NMI
// synchronisers. Define BUS_TRACE_EN to add the access trace ring.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 8,
  parameter int unsigned DIV         = 1,
  parameter int unsigned WAIT_MAX    = 7,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [AW-1:0]                   cpu_ab,
  input  logic [DW-1:0]                   cpu_dbo,
  input  logic                            cpu_we,
  output logic                            cpu_rdy,
  output logic [DW-1:0]                   cpu_dbi,
  input  logic                            irq_n,
  input  logic                            nmi_n,
  output logic                            cpu_irq,
  output logic                            cpu_nmi,
  output logic [AW-1:0]                   mem_ab,
  output logic [DW-1:0]                   mem_dbo,
  output logic                            mem_we,
  output logic                            mem_req,
  input  logic                            mem_ack,
  input  logic [DW-1:0]                   mem_dbi,
  input  logic [$clog2(WAIT_MAX+1)-1:0]   wait_cfg
`ifdef BUS_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0]  trace_idx,
  output logic [AW-1:0]                   trace_ab,
  output logic                            trace_we,
  output logic [$clog2(TRACE_DEPTH):0]    trace_cnt
`endif
);

  localparam int unsigned WW  = $clog2(WAIT_MAX+1);
  localparam int unsigned DVW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_bad_div
    $error("DIV must be at least 1");
  end
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("TRACE_DEPTH must be a power of two, at least 2");
  end

  bus_state_e     state_q, state_d;
  logic [DVW-1:0] div_q, div_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic [AW-1:0]  mem_ab_q, mem_ab_d;
  logic [DW-1:0]  mem_dbo_q, mem_dbo_d;
  logic [DW-1:0]  cpu_dbi_q, cpu_dbi_d;
  logic           mem_we_q, mem_we_d;
  logic           mem_req_q, mem_req_d;
  logic           irq_s1_q, irq_s2_q, nmi_s1_q, nmi_s2_q;
  logic           en;
  logic           done_go;

  assign en      = (div_q == '0);
  assign div_d   = (div_q == DVW'(DIV - 1)) ? '0 : div_q + DVW'(1);
  assign done_go = (state_q == REQ) && (wcnt_q == '0) && mem_ack;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = REQ;
      REQ:     if (done_go) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every variable gets a default first, so no branch can infer a latch.
  always_comb begin
    mem_ab_d  = mem_ab_q;
    mem_dbo_d = mem_dbo_q;
    mem_we_d  = mem_we_q;
    mem_req_d = mem_req_q;
    cpu_dbi_d = cpu_dbi_q;
    wcnt_d    = wcnt_q;
    cpu_rdy   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          mem_ab_d  = cpu_ab;
          mem_dbo_d = cpu_dbo;
          mem_we_d  = cpu_we;
          mem_req_d = 1'b1;
          wcnt_d    = WW'(clamp_wait(32'(wait_cfg), WAIT_MAX));
        end
      end
      REQ: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WW'(1);
        end else if (mem_ack) begin
          // Dropping mem_we with mem_req keeps a write strobe from outliving its request.
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) cpu_dbi_d = mem_dbi;
        end
      end
      DONE:    cpu_rdy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q     <= '0;
      wcnt_q    <= '0;
      mem_ab_q  <= '0;
      mem_dbo_q <= '0;
      mem_we_q  <= 1'b0;
      mem_req_q <= 1'b0;
      cpu_dbi_q <= '0;
      irq_s1_q  <= 1'b1;
      irq_s2_q  <= 1'b1;
      nmi_s1_q  <= 1'b1;
      nmi_s2_q  <= 1'b1;
    end else begin
      div_q     <= div_d;
      wcnt_q    <= wcnt_d;
      mem_ab_q  <= mem_ab_d;
      mem_dbo_q <= mem_dbo_d;
      mem_we_q  <= mem_we_d;
      mem_req_q <= mem_req_d;
      cpu_dbi_q <= cpu_dbi_d;
      irq_s1_q  <= irq_n;
      irq_s2_q  <= irq_s1_q;
      nmi_s1_q  <= nmi_n;
      nmi_s2_q  <= nmi_s1_q;
    end
  end

  assign mem_ab  = mem_ab_q;
  assign mem_dbo = mem_dbo_q;
  assign mem_we  = mem_we_q;
  assign mem_req = mem_req_q;
  assign cpu_dbi = cpu_dbi_q;
  assign cpu_irq = ~irq_s2_q;
  assign cpu_nmi = ~nmi_s2_q;

`ifdef BUS_TRACE_EN
  // Logged on the completing edge, while mem_ab/mem_we still describe the access.
  bus_trace_ring #(
    .AW    (AW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (done_go),
    .ab_i     (mem_ab_q),
    .we_i     (mem_we_q),
    .rd_idx_i (trace_idx),
    .rd_ab_o  (trace_ab),
    .rd_we_o  (trace_we),
    .cnt_o    (trace_cnt)
  );
`endif

endmodule
